water: RTL and testbench
========================

WATER -- requirements
Module: water

Interface
REQ-001 Parameter DRY_TH, default 8'd64: Moisture_sensor strictly below this is "dry".
REQ-002 Parameter WET_TH, default 8'd128: Moisture_sensor at or above this is "wet"; DRY_TH < WET_TH SHALL hold.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Moisture_sensor  input  8  unsigned soil moisture (0 = driest, 255 = wettest).
REQ-006 Water_sensor  input  2  tank level: 00 empty, 01 low, 10 medium, 11 full.
REQ-007 Pump  output  1  registered; 1 = tank refill pump running.
REQ-008 Sprinkler  output  1  registered; 1 = irrigation sprinkler open.
REQ-009 Positional port order SHALL be: Moisture_sensor, Water_sensor, CLK, Pump, Sprinkler, Reset.

Function
REQ-010 Two independent FSMs: pump FSM {P_OFF, P_FILL}; sprinkler FSM {S_OFF, S_ON}.
REQ-011 Pump = 1 iff pump FSM is P_FILL; Sprinkler = 1 iff sprinkler FSM is S_ON; outputs SHALL be driven directly from state registers (no combinational path from inputs).
REQ-012 P_OFF -> P_FILL when Water_sensor is 00 or 01.
REQ-013 P_FILL -> P_OFF when Water_sensor is 11; level 10 SHALL hold the current pump state (hysteresis).
REQ-014 S_OFF -> S_ON when Moisture_sensor < DRY_TH and Water_sensor != 00.
REQ-015 S_ON -> S_OFF when Moisture_sensor >= WET_TH or Water_sensor == 00 (dry-run protection takes priority over moisture).
REQ-016 Moisture in [DRY_TH, WET_TH) SHALL hold the current sprinkler state.
REQ-017 Comparisons SHALL be unsigned 8-bit; boundaries: 63 is dry, 64 is not dry, 127 is not wet, 128 is wet (default parameters).
REQ-018 Latency: an input change before rising edge N SHALL be reflected on Pump/Sprinkler after edge N (one cycle); no further filtering.
REQ-019 Pump and Sprinkler MAY be 1 simultaneously (e.g. level 01 and dry soil).
REQ-020 Sprinkler SHALL never transition to or remain in S_ON on any cycle where the sampled Water_sensor is 00.
REQ-021 Decisions SHALL use only the values sampled at the current edge; no memory beyond the two FSM states.

Reset
REQ-022 When Reset is 1 at a rising edge, both FSMs SHALL go to OFF states, Pump = 0, Sprinkler = 0, regardless of inputs.
REQ-023 Reset SHALL take priority over all transitions, including mid-fill and mid-irrigation.
REQ-024 Before the first reset, output values are unspecified; after reset deasserts, normal transitions SHALL resume on the next edge.
REQ-025 Outputs SHALL remain 0 after reset until a transition condition is sampled with valid inputs.

Verification
REQ-026 Reset pulse, then Moisture=32, Water=10 -> after one edge Sprinkler=1, Pump=0.
REQ-027 From S_ON: Moisture=160, Water=10 -> Sprinkler=0, Pump=0.
REQ-028 Moisture=32, Water=01 -> Sprinkler=1, Pump=1; then Moisture=160, Water=11 -> Sprinkler=0, Pump=0.
REQ-029 Pump hysteresis: Water 01 -> Pump=1; Water 10 -> Pump stays 1; Water 11 -> Pump=0; Water 10 -> Pump stays 0.
REQ-030 Sprinkler boundaries/hysteresis: Moisture 64 from S_OFF -> 0; 63 -> 1; 127 -> stays 1; 128 -> 0; with Water=10.
REQ-031 Dry-run and reset: S_ON with Moisture=32, Water -> 00 -> Sprinkler=0, Pump=1; assert Reset one cycle -> both 0.

Source files
------------

// File: rtl/water_if.sv
// Sensor/actuator bundle for the irrigation controller.
// The master side drives the sensors and observes the pump and sprinkler.
interface water_if;
    logic [7:0] Moisture_sensor;
    logic [1:0] Water_sensor;
    logic       Pump;
    logic       Sprinkler;

    modport master (
        output Moisture_sensor,
        output Water_sensor,
        input  Pump,
        input  Sprinkler
    );

    modport slave (
        input  Moisture_sensor,
        input  Water_sensor,
        output Pump,
        output Sprinkler
    );
endinterface

// File: rtl/water.sv
// Irrigation controller with two independent FSMs: tank refill pump and sprinkler.
// Both outputs come straight from state flops, so inputs reach them one edge later.
module water #(
    parameter logic [7:0] DRY_TH = 8'd64,   // moisture below this is dry
    parameter logic [7:0] WET_TH = 8'd128   // moisture at or above this is wet
) (
    input  logic [7:0] Moisture_sensor,
    input  logic [1:0] Water_sensor,
    input  logic       CLK,
    output logic       Pump,
    output logic       Sprinkler,
    input  logic       Reset
);

    typedef enum logic {P_OFF, P_FILL} pump_state_t;
    typedef enum logic {S_OFF, S_ON}   spr_state_t;

    localparam logic [1:0] LVL_EMPTY  = 2'b00;
    localparam logic [1:0] LVL_LOW    = 2'b01;
    localparam logic [1:0] LVL_FULL   = 2'b11;

    pump_state_t pump_state, pump_next;
    spr_state_t  spr_state,  spr_next;

    logic is_dry;
    logic is_wet;
    logic tank_empty;

    assign is_dry     = Moisture_sensor <  DRY_TH;
    assign is_wet     = Moisture_sensor >= WET_TH;
    assign tank_empty = Water_sensor == LVL_EMPTY;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pump_state <= P_OFF;
            spr_state  <= S_OFF;
        end else begin
            pump_state <= pump_next;
            spr_state  <= spr_next;
        end
    end

    // NOTE: next-state defaults to the current state before any branch, so no
    // path through this block leaves a variable unassigned (no latch).
    always_comb begin
        pump_next = pump_state;
        unique case (pump_state)
            P_OFF:  if (Water_sensor == LVL_EMPTY || Water_sensor == LVL_LOW)
                        pump_next = P_FILL;
            P_FILL: if (Water_sensor == LVL_FULL)
                        pump_next = P_OFF;
            default: pump_next = P_OFF;
        endcase
    end

    // An empty tank forces the sprinkler off ahead of any moisture decision.
    always_comb begin
        spr_next = spr_state;
        unique case (spr_state)
            S_OFF:  if (is_dry && !tank_empty)
                        spr_next = S_ON;
            S_ON:   if (is_wet || tank_empty)
                        spr_next = S_OFF;
            default: spr_next = S_OFF;
        endcase
    end

    assign Pump      = (pump_state == P_FILL);
    assign Sprinkler = (spr_state  == S_ON);

endmodule

// File: tb/tb_water.sv
// Scoreboard bench for water: stimulus pushes model predictions, monitor pops
// and compares them one edge later.
module tb_water;

    localparam logic [7:0] DRY_TH = 8'd64;
    localparam logic [7:0] WET_TH = 8'd128;

    logic CLK;
    logic Reset;

    water_if wif ();

    water #(.DRY_TH(DRY_TH), .WET_TH(WET_TH)) dut (
        .Moisture_sensor (wif.Moisture_sensor),
        .Water_sensor    (wif.Water_sensor),
        .CLK             (CLK),
        .Pump            (wif.Pump),
        .Sprinkler       (wif.Sprinkler),
        .Reset           (Reset)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pump;
        logic spr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain rule evaluation on two bits of remembered state.
    bit m_pump;
    bit m_spr;

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs; the model predicts the outputs after the edge.
    task automatic step(input logic [7:0] m, input logic [1:0] w, input logic r);
        exp_t e;
        @(negedge CLK);
        wif.Moisture_sensor = m;
        wif.Water_sensor    = w;
        Reset               = r;
        if (r) begin
            m_pump = 0;
            m_spr  = 0;
        end else begin
            if (w <= 2'd1)      m_pump = 1;
            else if (w == 2'd3) m_pump = 0;
            if (w == 2'd0)          m_spr = 0;
            else if (m < DRY_TH)    m_spr = 1;
            else if (m >= WET_TH)   m_spr = 0;
        end
        e.pump = m_pump;
        e.spr  = m_spr;
        exp_q.push_back(e);
        @(posedge CLK);
    endtask

    // Monitor: every edge that has a prediction queued is compared 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pump", wif.Pump, e.pump);
                check("sprinkler", wif.Sprinkler, e.spr);
            end
        end
    end

    function automatic logic [7:0] pick_moisture();
        logic [7:0] edges [6];
        edges = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd255};
        if ($urandom_range(0, 2) == 0)
            return edges[$urandom_range(0, 5)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int waited;
        wif.Moisture_sensor = 8'd0;
        wif.Water_sensor    = 2'b00;
        Reset               = 1'b1;

        // Reset, then dry soil with medium tank.
        step(8'd32, 2'b10, 1'b1);
        step(8'd32, 2'b10, 1'b0);
        step(8'd160, 2'b10, 1'b0);
        // Pump and sprinkler together, then both off.
        step(8'd32, 2'b01, 1'b0);
        step(8'd160, 2'b11, 1'b0);
        // Pump hysteresis.
        step(8'd100, 2'b01, 1'b0);
        step(8'd100, 2'b10, 1'b0);
        step(8'd100, 2'b11, 1'b0);
        step(8'd100, 2'b10, 1'b0);
        // Sprinkler boundaries from S_OFF.
        step(8'd64,  2'b10, 1'b0);
        step(8'd63,  2'b10, 1'b0);
        step(8'd127, 2'b10, 1'b0);
        step(8'd128, 2'b10, 1'b0);
        // Dry-run protection, then reset mid-fill.
        step(8'd32, 2'b01, 1'b0);
        step(8'd32, 2'b00, 1'b0);
        step(8'd32, 2'b00, 1'b1);
        step(8'd32, 2'b01, 1'b0);

        for (int i = 0; i < 2000; i++)
            step(pick_moisture(), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 31) == 0));

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge CLK);
            waited++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
